// File: rtl/gate_truth_table_checker.sv
// Sweeps all four {a,b} vectors into a 2-input gate and checks its output.
// Optional CHECKER_FAIL_MASK_EN adds a per-vector fail_mask output.
module gate_truth_table_checker #(
    parameter logic [3:0]  EXPECT        = 4'b0001,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] vec_idx
`ifdef CHECKER_FAIL_MASK_EN
    ,
    output logic [3:0] fail_mask
`endif
);

    localparam logic [3:0] LP_SETTLE = SETTLE_CYCLES[3:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic [1:0] r_vec;
    logic [1:0] w_vec_nxt;
    logic [2:0] r_err;
    logic [2:0] w_err_nxt;
    logic [2:0] w_err_inc;
    logic       r_busy;
    logic       w_busy_nxt;
    logic       r_done;
    logic       w_done_nxt;
    logic       r_pass;
    logic       w_pass_nxt;
    logic       w_mis;
`ifdef CHECKER_FAIL_MASK_EN
    logic [3:0] r_mask;
    logic [3:0] w_mask_nxt;
`endif

    // Next-state and next-output logic for the sweep FSM
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_vec_nxt   = r_vec;
        w_err_nxt   = r_err;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
        w_pass_nxt  = r_pass;
`ifdef CHECKER_FAIL_MASK_EN
        w_mask_nxt  = r_mask;
`endif
        // X/Z on the gate output is a mismatch, hence case inequality
        w_mis     = (dut_y !== EXPECT[r_vec]);
        w_err_inc = (r_err == 3'd4) ? r_err : r_err + 3'd1;

        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_APPLY;
                    w_vec_nxt   = 2'd0;
                    w_err_nxt   = 3'd0;
                    w_busy_nxt  = 1'b1;
                    w_done_nxt  = 1'b0;
                    w_pass_nxt  = 1'b0;
`ifdef CHECKER_FAIL_MASK_EN
                    w_mask_nxt  = 4'd0;
`endif
                end
            end
            S_APPLY: begin
                if (LP_SETTLE != 4'd0) begin
                    w_cnt_nxt   = LP_SETTLE;
                    w_state_nxt = S_SETTLE;
                end else begin
                    w_state_nxt = S_SAMPLE;
                end
            end
            S_SETTLE: begin
                if (r_cnt <= 4'd1) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = S_SAMPLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_SAMPLE: begin
                if (w_mis) begin
                    w_err_nxt = w_err_inc;
`ifdef CHECKER_FAIL_MASK_EN
                    w_mask_nxt[r_vec] = 1'b1;
`endif
                end
                if (r_vec != 2'd3) begin
                    w_vec_nxt   = r_vec + 2'd1;
                    w_state_nxt = S_APPLY;
                end else begin
                    w_state_nxt = S_DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = (w_err_nxt == 3'd0);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_vec   <= 2'd0;
            r_err   <= 3'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
`ifdef CHECKER_FAIL_MASK_EN
            r_mask  <= 4'd0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_vec   <= w_vec_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
`ifdef CHECKER_FAIL_MASK_EN
            r_mask  <= w_mask_nxt;
`endif
        end
    end

    assign a         = r_vec[1];
    assign b         = r_vec[0];
    assign vec_idx   = r_vec;
    assign err_count = r_err;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
`ifdef CHECKER_FAIL_MASK_EN
    assign fail_mask = r_mask;
`endif

endmodule
